// File: rtl/if_pkg.sv
// Shared constants and branch-target arithmetic for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned PC_INC = 4;

  // Computed at 64 bits; callers truncate to their address width for modulo wrap.
  function automatic logic [63:0] branch_target(input logic [63:0] br_pc,
                                                input logic [63:0] offset,
                                                input int unsigned off_w);
    logic [63:0]        off_shl;
    logic signed [63:0] off_sext;
    off_shl  = offset << (64 - off_w);
    off_sext = $signed(off_shl) >>> (64 - off_w);
    return br_pc + 64'(PC_INC) + (off_sext <<< 2);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries with single-cycle flush.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push && !flush) mem_q[tail_q] <= wdata;
    end
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC, issues 1-cycle-latency memory reads and queues results for decode.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       OFF_W    = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [OFF_W-1:0]   br_offset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc_q, pc_d, tag_q, tag_d, br_target;
  logic              inflight_q, inflight_d;
  logic              issue, push, pop, credit_ok;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_head;

  assign br_target = ADDR_W'(branch_target(64'(br_pc), 64'(br_offset), OFF_W));

  // Pops this cycle are not credited, keeping the issue path off the decode ready.
  assign credit_ok = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH);
  assign issue     = !rst && !br_taken && !fifo_full && credit_ok;

  assign imem_req_valid = issue;
  assign imem_req_addr  = pc_q;

  assign push      = inflight_q && !br_taken;
  assign out_valid = !fifo_empty && !br_taken;
  assign pop       = out_valid && out_ready;

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (br_taken) begin
      pc_d = br_target;
    end else if (issue) begin
      pc_d  = pc_q + ADDR_W'(PC_INC);
      tag_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (br_taken),
    .wdata ({tag_q, imem_rdata}),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_pc    = fifo_head[ENT_W-1:INSTR_W];
  assign out_instr = fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: stream, branch, self-loop, backpressure, wrap, async reset.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] imem_rdata = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0;
  logic [15:0] br_offset = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic [31:0] w_rdata = '0;
  logic        w_br_taken = 1'b0;
  logic [31:0] w_br_pc = '0;
  logic [15:0] w_br_offset = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_rdata     (imem_rdata),
    .br_taken       (br_taken),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  if_fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (w_req_valid),
    .imem_req_addr  (w_req_addr),
    .imem_rdata     (w_rdata),
    .br_taken       (w_br_taken),
    .br_pc          (w_br_pc),
    .br_offset      (w_br_offset),
    .out_valid      (w_out_valid),
    .out_ready      (w_out_ready),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc)
  );

  always @(posedge clk) begin
    imem_rdata <= 32'hA500_0000 | imem_req_addr;
    w_rdata    <= 32'hA500_0000 | w_req_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);

    // streaming with out_ready high
    step(); rst = 1'b0; out_ready = 1'b1;
    mid();
    chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c0_req_addr", imem_req_addr, 32'h0);
    chk("c0_out_valid", 32'(out_valid), 32'd0);
    step(); mid();
    chk("c1_req_addr", imem_req_addr, 32'h4);
    chk("c1_out_valid", 32'(out_valid), 32'd0);
    step(); mid();
    chk("c2_req_addr", imem_req_addr, 32'h8);
    chk("c2_out_valid", 32'(out_valid), 32'd1);
    chk("c2_out_pc", out_pc, 32'h0);
    chk("c2_out_instr", out_instr, 32'hA500_0000);
    chk("wrap_pc0", w_out_pc, 32'hFFFF_FFFC);
    step(); mid();
    chk("c3_out_pc", out_pc, 32'h4);
    chk("wrap_pc1", w_out_pc, 32'h0000_0000);
    step(); mid();
    chk("c4_out_pc", out_pc, 32'h8);
    chk("wrap_pc2", w_out_pc, 32'h0000_0004);
    chk("wrap_instr2", w_out_instr, 32'hA500_0004);
    step(); mid();
    chk("c5_out_pc", out_pc, 32'hC);
    chk("c5_req_addr", imem_req_addr, 32'h14);

    // forward branch: 0x10 + 4 + 3*4 = 0x20
    step(); br_taken = 1'b1; br_pc = 32'h10; br_offset = 16'h0003;
    mid();
    chk("fbr_t_out_valid", 32'(out_valid), 32'd0);
    chk("fbr_t_req_valid", 32'(imem_req_valid), 32'd0);
    step(); br_taken = 1'b0;
    mid();
    chk("fbr_t1_req_addr", imem_req_addr, 32'h20);
    chk("fbr_t1_out_valid", 32'(out_valid), 32'd0);
    step(); mid();
    chk("fbr_t2_out_valid", 32'(out_valid), 32'd0);
    step(); mid();
    chk("fbr_t3_out_valid", 32'(out_valid), 32'd1);
    chk("fbr_t3_out_pc", out_pc, 32'h20);
    step(); mid();
    chk("fbr_t4_out_pc", out_pc, 32'h24);

    // backward branch to itself: 0x20 + 4 - 4 = 0x20
    for (int rep = 0; rep < 2; rep++) begin
      step(); br_taken = 1'b1; br_pc = 32'h20; br_offset = 16'hFFFF;
      mid();
      chk("loop_br_out_valid", 32'(out_valid), 32'd0);
      step(); br_taken = 1'b0;
      mid();
      chk("loop_req_addr", imem_req_addr, 32'h20);
      step(); step(); mid();
      chk("loop_out_pc0", out_pc, 32'h20);
      step(); mid();
      chk("loop_out_pc1", out_pc, 32'h24);
    end

    // backpressure from reset
    step(); rst = 1'b1; out_ready = 1'b0;
    step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_req_addr", imem_req_addr, 32'(4 * i));
      step();
    end
    mid();
    chk("bp_c4_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_c4_out_pc", out_pc, 32'h0);
    step(); mid();
    chk("bp_c5_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_c5_out_pc", out_pc, 32'h0);
    chk("bp_c5_out_instr", out_instr, 32'hA500_0000);
    step(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
      chk("bp_drain_pc", out_pc, 32'(4 * i));
      step();
    end

    // async reset with 3 queued and one in flight
    rst = 1'b1; out_ready = 1'b0;
    step(); rst = 1'b0;
    step(); step(); step(); step();
    mid();
    chk("ar_pre_out_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_req_valid", 32'(imem_req_valid), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_req_valid", 32'(imem_req_valid), 32'd0);
    chk("ar_out_pc", out_pc, 32'h0);
    #1 rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("ar_rel_req_valid", 32'(imem_req_valid), 32'd1);
    chk("ar_rel_req_addr", imem_req_addr, 32'h0);
    mid();
    chk("ar_n1_out_valid", 32'(out_valid), 32'd0);
    chk("ar_n1_req_addr", imem_req_addr, 32'h4);
    mid();
    chk("ar_n2_out_valid", 32'(out_valid), 32'd1);
    chk("ar_n2_out_pc", out_pc, 32'h0);
    chk("ar_n2_out_instr", out_instr, 32'hA500_0000);
    mid();
    chk("ar_n3_out_pc", out_pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
